// File: rtl/pic_host_sequencer.sv
// Host-side write/acknowledge sequencer for an 8259A-compatible PIC.
// Optional build macro PIC_AUTO_EOI_EN: ICW4 gets AEOI set and no EOI write follows vec_ack.
`timescale 1ns/1ps
module pic_host_sequencer #(
    parameter int PULSE_CYC = 2,
    parameter int GAP_CYC   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] icw1,
    input  logic [7:0] icw2,
    input  logic [7:0] icw3,
    input  logic [7:0] icw4,
    input  logic [7:0] ocw1,
    input  logic       pic_int,
    input  logic [7:0] pic_dout,
    output logic [7:0] pic_din,
    output logic       cs_n,
    output logic       wr_n,
    output logic       rd_n,
    output logic       a0,
    output logic       inta_n,
    output logic       vec_valid,
    output logic [7:0] vec,
    input  logic       vec_ack,
    output logic       init_done,
    output logic       busy
);

    typedef enum logic [3:0] {
        IDLE, WR_SETUP, WR_LOW, WR_HOLD, WR_GAP,
        READY, ACK1, ACK_GAP, ACK2, VEC_WAIT
    } state_t;

    typedef enum logic [2:0] {
        B_ICW1, B_ICW2, B_ICW3, B_ICW4, B_OCW1, B_EOI
    } byte_t;

    localparam logic [15:0] PULSE_LAST = 16'(PULSE_CYC - 1);
    localparam logic [15:0] GAP_LAST   = 16'(GAP_CYC - 1);

    state_t      state, state_nx;
    byte_t       step, step_nx;
    logic [15:0] cnt;
    logic        int_m, int_s;
    logic [7:0]  icw2_r, icw3_r, icw4_r, ocw1_r;
    logic [1:0]  icw1_r;
    logic        load, accept, capture, done_set;
    logic        last_pulse, last_gap;
    logic [7:0]  din_nx;
    logic        a0_nx;

    function automatic logic [7:0] icw4_byte(input logic [7:0] b);
`ifdef PIC_AUTO_EOI_EN
        return b | 8'h02;
`else
        return b;
`endif
    endfunction

    always_comb begin
        state_nx   = state;
        step_nx    = step;
        load       = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        done_set   = 1'b0;
        last_pulse = (cnt == PULSE_LAST);
        last_gap   = (cnt == GAP_LAST);
        case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    load     = 1'b1;
                    step_nx  = B_ICW1;
                    state_nx = WR_SETUP;
                end
            end
            WR_SETUP: state_nx = WR_LOW;
            WR_LOW:   if (last_pulse) state_nx = WR_HOLD;
            WR_HOLD:  state_nx = WR_GAP;
            WR_GAP: begin
                if (last_gap) begin
                    state_nx = WR_SETUP;
                    load     = 1'b1;
                    // ICW3 is skipped in single mode, ICW4 only when IC4 is requested
                    case (step)
                        B_ICW1: step_nx = B_ICW2;
                        B_ICW2: step_nx = !icw1_r[1] ? B_ICW3 :
                                          (icw1_r[0] ? B_ICW4 : B_OCW1);
                        B_ICW3: step_nx = icw1_r[0] ? B_ICW4 : B_OCW1;
                        B_ICW4: step_nx = B_OCW1;
                        B_OCW1: begin
                            state_nx = READY;
                            load     = 1'b0;
                            done_set = 1'b1;
                        end
                        default: begin
                            state_nx = READY;
                            load     = 1'b0;
                        end
                    endcase
                end
            end
            READY: begin
                if (start) begin
                    accept   = 1'b1;
                    load     = 1'b1;
                    step_nx  = B_ICW1;
                    state_nx = WR_SETUP;
                end else if (int_s) begin
                    state_nx = ACK1;
                end
            end
            ACK1:    if (last_pulse) state_nx = ACK_GAP;
            ACK_GAP: if (last_gap) state_nx = ACK2;
            ACK2: begin
                if (last_pulse) begin
                    capture  = 1'b1;
                    state_nx = VEC_WAIT;
                end
            end
            VEC_WAIT: begin
                if (vec_ack) begin
`ifdef PIC_AUTO_EOI_EN
                    state_nx = READY;
`else
                    state_nx = WR_SETUP;
                    step_nx  = B_EOI;
                    load     = 1'b1;
`endif
                end
            end
            default: state_nx = IDLE;
        endcase

        case (step_nx)
            B_ICW1:  din_nx = icw1;
            B_ICW2:  din_nx = icw2_r;
            B_ICW3:  din_nx = icw3_r;
            B_ICW4:  din_nx = icw4_byte(icw4_r);
            B_OCW1:  din_nx = ocw1_r;
            default: din_nx = 8'h20;
        endcase
        a0_nx = !(step_nx == B_ICW1 || step_nx == B_EOI);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            step      <= B_ICW1;
            cnt       <= '0;
            int_m     <= 1'b0;
            int_s     <= 1'b0;
            pic_din   <= 8'h00;
            a0        <= 1'b0;
            vec       <= 8'h00;
            init_done <= 1'b0;
        end else begin
            state <= state_nx;
            step  <= step_nx;
            cnt   <= (state_nx != state) ? 16'd0 : cnt + 16'd1;
            int_m <= pic_int;
            int_s <= int_m;
            if (load) begin
                pic_din <= din_nx;
                a0      <= a0_nx;
            end
            if (capture) vec <= pic_dout;
            if (accept) init_done <= 1'b0;
            else if (done_set) init_done <= 1'b1;
        end
    end

    // Config bytes are plain data, captured once per accepted start
    always_ff @(posedge clk) begin
        if (accept) begin
            icw1_r <= icw1[1:0];
            icw2_r <= icw2;
            icw3_r <= icw3;
            icw4_r <= icw4;
            ocw1_r <= ocw1;
        end
    end

    assign cs_n      = !(state == WR_SETUP || state == WR_LOW || state == WR_HOLD);
    assign wr_n      = (state != WR_LOW);
    assign rd_n      = 1'b1;
    assign inta_n    = !(state == ACK1 || state == ACK2);
    assign vec_valid = (state == VEC_WAIT);
    assign busy      = !(state == IDLE || state == READY);

endmodule

// File: tb/tb_pic_host_sequencer.sv
// Scoreboard bench for pic_host_sequencer: expected PIC writes are queued and checked by a bus monitor.
`timescale 1ns/1ps
module tb_pic_host_sequencer;
    localparam int PULSE_CYC = 2;
    localparam int GAP_CYC   = 1;
    localparam int WR_CYC    = 2 + PULSE_CYC + GAP_CYC;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] icw1 = 8'h00, icw2 = 8'h00, icw3 = 8'h00, icw4 = 8'h00, ocw1 = 8'h00;
    logic       pic_int = 1'b0;
    logic [7:0] pic_dout = 8'hEE;
    logic [7:0] pic_din;
    logic       cs_n, wr_n, rd_n, a0, inta_n, vec_valid;
    logic [7:0] vec;
    logic       vec_ack = 1'b0;
    logic       init_done, busy;

    int passed = 0;
    int total  = 0;
    logic [8:0] exp_q[$];
    logic [8:0] mon_exp;
    logic wr_prev = 1'b1;
    bit   abort = 1'b0;
    int   wr_width = 0;

    pic_host_sequencer #(.PULSE_CYC(PULSE_CYC), .GAP_CYC(GAP_CYC)) dut (
        .clk(clk), .rst(rst), .start(start),
        .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4), .ocw1(ocw1),
        .pic_int(pic_int), .pic_dout(pic_dout), .pic_din(pic_din),
        .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n), .a0(a0), .inta_n(inta_n),
        .vec_valid(vec_valid), .vec(vec), .vec_ack(vec_ack),
        .init_done(init_done), .busy(busy)
    );

    always #5 clk = ~clk;

    // Bus monitor: each wr_n falling edge pops one expected (a0,data) pair
    always @(negedge clk) begin
        if (wr_prev === 1'b1 && wr_n === 1'b0) begin
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL write_unexpected: got a0=%0b data=%02h, required no write", a0, pic_din);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({a0, pic_din} !== mon_exp || cs_n !== 1'b0)
                    $display("FAIL write_data: got a0=%0b data=%02h cs_n=%0b, required a0=%0b data=%02h cs_n=0",
                             a0, pic_din, cs_n, mon_exp[8], mon_exp[7:0]);
                else passed++;
            end
            wr_width = 0;
            abort = 1'b0;
        end
        if (wr_n === 1'b0) begin
            wr_width++;
            if (rst) abort = 1'b1;
        end
        if (wr_prev === 1'b0 && wr_n === 1'b1 && !abort) begin
            total++;
            if (wr_width != PULSE_CYC)
                $display("FAIL wr_pulse_width: got %0d, required %0d", wr_width, PULSE_CYC);
            else passed++;
        end
        wr_prev = wr_n;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_icw4(input logic [7:0] b);
`ifdef PIC_AUTO_EOI_EN
        return b | 8'h02;
`else
        return b;
`endif
    endfunction

    task automatic push_eoi;
`ifndef PIC_AUTO_EOI_EN
        exp_q.push_back({1'b0, 8'h20});
`endif
    endtask

    task automatic push_init(input logic [7:0] i1, i2, i3, i4, o1, output int n);
        n = 0;
        exp_q.push_back({1'b0, i1}); n++;
        exp_q.push_back({1'b1, i2}); n++;
        if (!i1[1]) begin exp_q.push_back({1'b1, i3}); n++; end
        if (i1[0])  begin exp_q.push_back({1'b1, exp_icw4(i4)}); n++; end
        exp_q.push_back({1'b1, o1}); n++;
    endtask

    task automatic test_reset;
        int errs;
        rst = 1'b1; start = 1'b0; vec_ack = 1'b0; pic_int = 1'b0;
        tick; tick;
        total++;
        if ({cs_n, wr_n, rd_n, inta_n} !== 4'b1111)
            $display("FAIL reset_strobes: got %b, required 1111", {cs_n, wr_n, rd_n, inta_n});
        else passed++;
        total++;
        if ({a0, pic_din, vec} !== 17'h0)
            $display("FAIL reset_data: got a0=%0b din=%02h vec=%02h, required 0/00/00", a0, pic_din, vec);
        else passed++;
        total++;
        if ({vec_valid, init_done, busy} !== 3'b000)
            $display("FAIL reset_status: got %b, required 000", {vec_valid, init_done, busy});
        else passed++;
        rst = 1'b0;
        pic_int = 1'b1;
        errs = 0;
        repeat (8) begin
            tick;
            if (inta_n !== 1'b1 || busy !== 1'b0) errs++;
        end
        pic_int = 1'b0;
        total++;
        if (errs != 0) $display("FAIL idle_int_ignored: got %0d bad cycles, required 0", errs);
        else passed++;
        repeat (3) tick;
    endtask

    task automatic test_init(input logic [7:0] i1, i2, i3, i4, o1, input bit glitch);
        int n, cycles;
        push_init(i1, i2, i3, i4, o1, n);
        icw1 = i1; icw2 = i2; icw3 = i3; icw4 = i4; ocw1 = o1;
        start = 1'b1;
        tick;
        start = 1'b0;
        icw1 = 8'hFF; icw2 = 8'hFF; icw3 = 8'hFF; icw4 = 8'hFF; ocw1 = 8'hFF;
        cycles = 0;
        while (cycles < 200) begin
            tick;
            cycles++;
            if (glitch && cycles == 3) start = 1'b1;
            if (cycles == 4) start = 1'b0;
            if (init_done === 1'b1) break;
        end
        total++;
        if (cycles != n * WR_CYC)
            $display("FAIL init_cycles icw1=%02h: got %0d, required %0d", i1, cycles, n * WR_CYC);
        else passed++;
        total++;
        if (exp_q.size() != 0 || busy !== 1'b0)
            $display("FAIL init_complete icw1=%02h: got %0d writes left busy=%0b, required 0/0", i1, exp_q.size(), busy);
        else passed++;
    endtask

    task automatic test_ack(input logic [7:0] v);
        int c, errs;
        pic_dout = 8'hEE;
        pic_int = 1'b1;
        c = 0;
        while (c < 20 && inta_n !== 1'b0) begin tick; c++; end
        total++;
        if (c != 3) $display("FAIL int_latency: got %0d, required 3", c);
        else passed++;
        errs = 0;
        for (int i = 0; i < PULSE_CYC - 1; i++) begin tick; if (inta_n !== 1'b0) errs++; end
        pic_int = 1'b0;
        for (int i = 0; i < GAP_CYC; i++) begin tick; if (inta_n !== 1'b1) errs++; end
        for (int i = 0; i < PULSE_CYC; i++) begin
            tick;
            if (inta_n !== 1'b0) errs++;
            pic_dout = (i == PULSE_CYC - 1) ? v : 8'hEE;
        end
        total++;
        if (errs != 0) $display("FAIL inta_pulses: got %0d bad cycles, required 0", errs);
        else passed++;
        tick;
        pic_dout = 8'hEE;
        total++;
        if (vec_valid !== 1'b1 || vec !== v || inta_n !== 1'b1)
            $display("FAIL vec_capture: got valid=%0b vec=%02h, required 1/%02h", vec_valid, vec, v);
        else passed++;
    endtask

    task automatic test_handshake;
        int errs, c;
        errs = 0;
        repeat (10) begin
            tick;
            if (vec_valid !== 1'b1 || cs_n !== 1'b1 || wr_n !== 1'b1 || inta_n !== 1'b1) errs++;
        end
        total++;
        if (errs != 0) $display("FAIL vec_hold: got %0d bad cycles, required 0", errs);
        else passed++;
        push_eoi();
        vec_ack = 1'b1;
        tick;
        vec_ack = 1'b0;
        total++;
        if (vec_valid !== 1'b0) $display("FAIL vec_ack_clear: got %0b, required 0", vec_valid);
        else passed++;
        c = 0;
        while (c < 50 && busy !== 1'b0) begin tick; c++; end
        repeat (3) tick;
        total++;
        if (busy !== 1'b0 || init_done !== 1'b1 || exp_q.size() != 0)
            $display("FAIL eoi_done: got busy=%0b init_done=%0b left=%0d, required 0/1/0", busy, init_done, exp_q.size());
        else passed++;
    endtask

    task automatic test_reset_mid;
        int c;
        exp_q.push_back({1'b0, 8'h13});
        icw1 = 8'h13; icw2 = 8'h40; icw3 = 8'h00; icw4 = 8'h01; ocw1 = 8'h00;
        start = 1'b1;
        tick;
        start = 1'b0;
        c = 0;
        while (c < 20 && wr_n !== 1'b0) begin tick; c++; end
        rst = 1'b1;
        tick;
        total++;
        if ({wr_n, cs_n, init_done, busy} !== 4'b1100)
            $display("FAIL reset_mid: got wr_n,cs_n,init_done,busy=%b, required 1100", {wr_n, cs_n, init_done, busy});
        else passed++;
        rst = 1'b0;
        tick;
        tick;
        exp_q.delete();
        total++;
        if (busy !== 1'b0 || cs_n !== 1'b1) $display("FAIL reset_mid_idle: got busy=%0b cs_n=%0b, required 0/1", busy, cs_n);
        else passed++;
    endtask

    task automatic test_priority;
        int c, n, errs;
        pic_dout = 8'h47;
        pic_int = 1'b1;
        c = 0;
        while (c < 20 && vec_valid !== 1'b1) begin tick; c++; end
        total++;
        if (vec_valid !== 1'b1 || vec !== 8'h47) $display("FAIL prio_vec1: got valid=%0b vec=%02h, required 1/47", vec_valid, vec);
        else passed++;
        push_eoi();
        push_init(8'h13, 8'h58, 8'h00, 8'h01, 8'hF0, n);
        icw1 = 8'h13; icw2 = 8'h58; icw3 = 8'h00; icw4 = 8'h01; ocw1 = 8'hF0;
        start = 1'b1;
        vec_ack = 1'b1;
        tick;
        vec_ack = 1'b0;
        pic_dout = 8'h52;
        c = 0;
        while (c < 20 && init_done !== 1'b0) begin tick; c++; end
        start = 1'b0;
        total++;
        if (init_done !== 1'b0) $display("FAIL prio_start_accept: got init_done=%0b, required 0", init_done);
        else passed++;
        errs = 0;
        c = 0;
        while (c < 60 && init_done !== 1'b1) begin
            tick; c++;
            if (inta_n !== 1'b1) errs++;
        end
        total++;
        if (errs != 0 || init_done !== 1'b1 || exp_q.size() != 0)
            $display("FAIL prio_init_first: got inta_low=%0d init_done=%0b left=%0d, required 0/1/0", errs, init_done, exp_q.size());
        else passed++;
        c = 0;
        while (c < 20 && vec_valid !== 1'b1) begin tick; c++; end
        pic_int = 1'b0;
        total++;
        if (vec_valid !== 1'b1 || vec !== 8'h52) $display("FAIL prio_vec2: got valid=%0b vec=%02h, required 1/52", vec_valid, vec);
        else passed++;
        test_handshake();
    endtask

    initial begin
        test_reset();
        test_init(8'h13, 8'h40, 8'h00, 8'h01, 8'h00, 1'b1);
        test_ack(8'h43);
        test_handshake();
        test_reset_mid();
        test_init(8'h11, 8'h08, 8'h04, 8'h01, 8'hFB, 1'b0);
        test_init(8'h12, 8'h20, 8'h55, 8'h77, 8'h0F, 1'b0);
        test_priority();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
